// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: access sizes, RAM rw strobe,
// sequencer states, owner ids, plus helpers for byte count and load extension.
// No logic of its own; imported by ram_byte_seq and ram_port_arbiter.
package ram_port_arbiter_pkg;

    // Data access size as presented on d_size; 2'd3 behaves as a word.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // RAM write strobe values.
    localparam logic RAM_RD = 1'b0;
    localparam logic RAM_WR = 1'b1;

    // Port owner ids, as reported on the owner debug output.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } st_t;

    // Number of byte beats for a data access.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Sign or zero extension of an assembled little-endian load word.
    function automatic logic [31:0] extend_load(input logic [31:0] w,
                                                input logic [1:0]  size,
                                                input logic        sext);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {{24{sext & w[7]}},  w[7:0]};
            SZ_HALF: r = {{16{sext & w[15]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_byte_seq.sv
// Byte sequencer: walks N byte addresses on the RAM port and packs read bytes little-endian.
// Latency: address k in cycle k+1 after start; stores finish in N+1, loads in N+2 (DONE cycle).
// No backpressure: the RAM accepts one byte per cycle; abort drops a read in ISSUE/DRAIN.
//
// Ports: start/base/nbytes/we/wdata launch a transaction from IDLE; abort returns to IDLE
// from ISSUE or DRAIN discarding captured data; state exposes the FSM; ram_a/ram_dout/ram_wr
// drive the RAM and ram_din returns the byte addressed one cycle earlier; rdata is the
// assembled word.
module ram_byte_seq
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [2:0]        nbytes,
    input  logic              we,
    input  logic [31:0]       wdata,
    input  logic              abort,
    input  logic [7:0]        ram_din,
    output st_t               state,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    output logic [31:0]       rdata
);

    st_t         state_nxt;
    logic [1:0]  cnt;        // index of the byte currently on ram_a
    logic [1:0]  last;       // index of the final byte (N-1)
    logic [1:0]  cnt_inc;
    logic [1:0]  cnt_dec;
    logic        is_last;
    logic        we_q;
    logic [23:0] wdata_q;    // store bytes still to be sent, next one in [7:0]

    assign cnt_inc = cnt + 2'd1;
    assign cnt_dec = cnt - 2'd1;
    assign is_last = (cnt == last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (is_last) begin
                    // Stores have nothing to wait for; reads still need the last byte back.
                    state_nxt = we_q ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nxt = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 2'd0;
            last     <= 2'd0;
            we_q     <= 1'b0;
            wdata_q  <= 24'd0;
            ram_a    <= '0;
            ram_dout <= 8'd0;
            ram_wr   <= RAM_RD;
            rdata    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Byte 0 is presented directly in the first ISSUE cycle.
                        cnt      <= 2'd0;
                        last     <= 2'(nbytes - 3'd1);
                        we_q     <= we;
                        wdata_q  <= wdata[31:8];
                        ram_a    <= base;
                        ram_dout <= wdata[7:0];
                        ram_wr   <= we ? RAM_WR : RAM_RD;
                        rdata    <= 32'd0;
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        ram_wr <= RAM_RD;
                        rdata  <= 32'd0;
                    end else begin
                        // ram_din now carries the byte addressed in the previous cycle.
                        if (!we_q && cnt != 2'd0) begin
                            rdata[{cnt_dec, 3'b000} +: 8] <= ram_din;
                        end
                        if (is_last) begin
                            ram_wr <= RAM_RD;
                        end else begin
                            cnt      <= cnt_inc;
                            ram_a    <= ram_a + ADDR_W'(1);
                            ram_dout <= wdata_q[7:0];
                            wdata_q  <= {8'd0, wdata_q[23:8]};
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        rdata <= 32'd0;
                    end else begin
                        rdata[{last, 3'b000} +: 8] <= ram_din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the byte-wide RAM port between instruction fetch (IF) and load/store (D).
// Latency: grant decided in IDLE; word read done 6 cycles later, byte store 2, word store 5.
// Backpressure: requesters hold req until their done pulse; IF may be aborted by if_flush.
//
// Ports: clk/rst; if_req/if_addr/if_flush in, if_done/if_rdata out; d_req/d_we/d_addr/
// d_wdata/d_size/d_sext in, d_done/d_rdata out; ram_a/ram_dout/ram_wr to the RAM,
// ram_din from it; owner reports the current or last grant (0 = IF, 1 = D).
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_sext,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic              owner
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    st_t               seq_state;
    logic              in_idle;
    logic              starved;
    logic              grant_d;
    logic              grant_if;
    logic              seq_start;
    logic              seq_abort;
    logic              seq_we;
    logic [ADDR_W-1:0] seq_base;
    logic [2:0]        seq_nbytes;
    logic [31:0]       word;
    logic [SW-1:0]     starve_cnt;
    logic [1:0]        d_size_q;
    logic              d_sext_q;

    // Arbitration happens only in IDLE; DONE never re-arbitrates, so a requester
    // always sees one IDLE cycle between its done and its next grant.
    assign in_idle  = (seq_state == ST_IDLE);
    assign starved  = (starve_cnt == STARVE_MAX) && if_req;
    assign grant_d  = in_idle && d_req && !starved;
    assign grant_if = in_idle && (d_req ? starved : (if_req && !if_flush));
    assign seq_start = grant_d || grant_if;

    assign seq_base   = grant_d ? d_addr : if_addr;
    assign seq_nbytes = grant_d ? size_nbytes(d_size) : 3'd4;
    assign seq_we     = grant_d && d_we;

    // Only a fetch in flight can be aborted; D transactions always run to completion.
    assign seq_abort = if_flush && (owner == OWN_IF) &&
                       (seq_state == ST_ISSUE || seq_state == ST_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            owner      <= OWN_IF;
            d_size_q   <= SZ_BYTE;
            d_sext_q   <= 1'b0;
        end else begin
            if (grant_if) begin
                starve_cnt <= '0;
                owner      <= OWN_IF;
            end else if (grant_d) begin
                owner    <= OWN_D;
                d_size_q <= d_size;
                d_sext_q <= d_sext;
                if (if_req && starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end
        end
    end

    ram_byte_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (seq_start),
        .base     (seq_base),
        .nbytes   (seq_nbytes),
        .we       (seq_we),
        .wdata    (d_wdata),
        .abort    (seq_abort),
        .ram_din  (ram_din),
        .state    (seq_state),
        .ram_a    (ram_a),
        .ram_dout (ram_dout),
        .ram_wr   (ram_wr),
        .rdata    (word)
    );

    assign if_done  = (seq_state == ST_DONE) && (owner == OWN_IF);
    assign d_done   = (seq_state == ST_DONE) && (owner == OWN_D);
    assign if_rdata = word;
    assign d_rdata  = extend_load(word, d_size_q, d_sext_q);

endmodule
